multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequential control unit for the multicycle datapath of our 32-bit single-memory CPU, replacing the purely combinational main decoder. It walks each instruction through fetch, decode, execute, memory and writeback states. Memory accesses wait on a ready handshake, and a parametrised timeout traps a stalled bus. It sits between the instruction register, the memory port and the datapath muxes, ALU control, PC and register-file enables.

## Interface
- OP_W, 6, opcode width
- FN_W, 6, R-type function field width
- TIMEOUT, 16, maximum wait cycles on mem_ready before bus-error trap (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  leave IDLE and begin fetching
- opcode  in  OP_W  instruction-register opcode field, valid from DECODE onward
- functi  in  FN_W  instruction-register function field
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write, ir_write, iord, mem_read, mem_write, reg_write, branch  out  1 each  datapath enables/selects
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_operation  out  2  00=add, 01=sub, 10=funct-decoded
- register_destination  out  2  00=rt, 01=rd, 10=r31
- memory_to_register  out  2  00=ALU result, 01=memory data, 10=PC
- pc_source  out  2  00=ALU, 01=ALUOut (branch), 10=jump target, 11=rs
- illegal, bus_error  out  1 each  sticky fault flags
- halted  out  1  controller is in TRAP

## Operation
- Opcodes: R=000000, LW=000001, SW=000010, ADDI=000011, SUBI=000100, BEQ=000101, J=000111, JAL=001000. JR is R-type with functi=001000.
- Moore outputs decoded from state. Any signal not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. When mem_ready=1, also ir_write=1 and pc_write=1 with pc_source=00, then go to DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (computes branch target). Next state by opcode:
  - LW or SW → MEMADR
  - R-type with functi=001000 → JR; any other R-type → EXEC
  - ADDI or SUBI → IEXEC
  - BEQ → BRANCH; J → JUMP; JAL → JAL
  - any other opcode → TRAP, setting illegal
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1, mem_read=1. Waits for mem_ready, then → MEMWB.
- MEMWB: reg_write=1, register_destination=00, memory_to_register=01. → FETCH.
- MEMWR: iord=1, mem_write=1. Waits for mem_ready, then → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. → ALUWB.
- ALUWB: reg_write=1, register_destination=01, memory_to_register=00. → FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI or 01 for SUBI. → IWB.
- IWB: reg_write=1, register_destination=00, memory_to_register=00. → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_source=01. The datapath forms the PC enable from branch & zero. → FETCH.
- JUMP: pc_write=1, pc_source=10. → FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, register_destination=10, memory_to_register=10. → FETCH.
- JR: pc_write=1, pc_source=11. → FETCH.
- TRAP: halted=1, all enables 0. Only reset exits TRAP; run is ignored.

## Timing
- Reset value of every output is 0. State resets to IDLE, the wait counter to 0, and illegal/bus_error to 0. Reset mid-instruction aborts immediately with no partial writes after release.
- Latency from FETCH entry, with zero-wait memory (mem_ready=1 on first cycle):
  - LW 5 cycles; SW, R-type, ADDI, SUBI 4 cycles
  - BEQ, J, JAL, JR 3 cycles
- Each memory wait cycle adds one cycle.
- Wait counter behaviour in FETCH, MEMRD and MEMWR:
  - Cleared on entering the state.
  - Incremented each cycle that mem_ready=0.
  - If mem_ready=0 while count==TIMEOUT-1, next state is TRAP and bus_error is set. The trap therefore follows TIMEOUT consecutive not-ready cycles.
  - If mem_ready=1 arrives on that same cycle, ready wins and execution proceeds normally.
- Counter width is clog2(TIMEOUT+1) and it never wraps.
- The opcode and functi inputs are sampled only in DECODE (and opcode in MEMADR/IEXEC), so IR changes elsewhere have no effect.

## Structure
- Package ctrl_pkg holds:
  - the opcode and JR-funct localparams
  - the state enum
  - the alu_op, alu_src_b, register_destination, memory_to_register and pc_source encodings
- Sub-module mem_wait_timer (parameter TIMEOUT) holds the wait counter. Ports: clear, ready, expired.
- The controller contains the state register, next-state logic and Moore output decode.

## Test plan
- Reset, then run=1 with LW and mem_ready always 1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. In MEMWB: reg_write=1, memory_to_register=01, register_destination=00.
- JAL, then R-type with functi=001000 → JAL asserts pc_write, register_destination=10, memory_to_register=10. The JR state asserts pc_source=11. Each instruction takes 3 cycles.
- SUBI → IEXEC shows alu_operation=01, then IWB shows reg_write=1. ADDI → alu_operation=00.
- Opcode 101010 → TRAP after DECODE with illegal=1 and halted=1. Toggling run leaves it there; reset clears it.
- SW with TIMEOUT=4 and mem_ready held 0 in MEMWR → bus_error=1 and TRAP after 4 wait cycles. A repeat run with mem_ready=1 on the 4th wait cycle → FETCH, no bus_error.
- Assert rst in the middle of a MEMRD wait → all outputs 0 immediately and state IDLE. After release, nothing happens until run=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and
// the datapath mux/ALU select codes driven by the controller.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_SUBI  = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {
    SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;
  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10} mem_to_reg_e;
  typedef enum logic [1:0] {
    PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11
  } pc_src_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access; expired flags the
// cycle on which the TIMEOUT-th not-ready cycle is being observed.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CAP  = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // Saturates at TIMEOUT so an idle or trapped controller never wraps it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!ready && (count_q != CAP)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = !ready && (count_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: walks each instruction through fetch, decode,
// execute, memory and writeback, with a bus-error trap on stalled memory.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FN_W    = 6,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] functi,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            branch,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_operation,
  output logic [1:0]      register_destination,
  output logic [1:0]      memory_to_register,
  output logic [1:0]      pc_source,
  output logic            illegal,
  output logic            bus_error,
  output logic            halted
);

  state_e state_q, state_d;
  logic   illegal_q, bus_error_q;
  logic   illegal_set, bus_error_set;
  logic   timer_expired;

  // Any state change restarts the count, so each wait state is entered at 0.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .ready   (mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_q | illegal_set;
      bus_error_q <= bus_error_q | bus_error_set;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can leave it unassigned (latch).
  always_comb begin
    state_d       = state_q;
    illegal_set   = 1'b0;
    bus_error_set = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timer_expired) begin
          state_d       = S_TRAP;
          bus_error_set = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_W'(OP_RTYPE)) begin
          state_d = (functi == FN_W'(FN_JR)) ? S_JR : S_EXEC;
        end else if (opcode == OP_W'(OP_ADDI) || opcode == OP_W'(OP_SUBI)) begin
          state_d = S_IEXEC;
        end else if (opcode == OP_W'(OP_BEQ)) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_W'(OP_J)) begin
          state_d = S_JUMP;
        end else if (opcode == OP_W'(OP_JAL)) begin
          state_d = S_JAL;
        end else begin
          state_d     = S_TRAP;
          illegal_set = 1'b1;
        end
      end
      S_MEMADR: state_d = (opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (timer_expired) begin
          state_d       = S_TRAP;
          bus_error_set = 1'b1;
        end
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write             = 1'b0;
    ir_write             = 1'b0;
    iord                 = 1'b0;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    reg_write            = 1'b0;
    branch               = 1'b0;
    alu_src_a            = 1'b0;
    alu_src_b            = SRCB_RT;
    alu_operation        = ALU_ADD;
    register_destination = DST_RT;
    memory_to_register   = WB_ALU;
    pc_source            = PC_ALU;
    halted               = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC capture only on the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write          = 1'b1;
        memory_to_register = WB_MEM;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write            = 1'b1;
        register_destination = DST_RD;
      end
      S_IEXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = (opcode == OP_W'(OP_SUBI)) ? ALU_SUB : ALU_ADD;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_SUB;
        branch        = 1'b1;
        pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_JUMP;
      end
      S_JAL: begin
        pc_write             = 1'b1;
        pc_source            = PC_JUMP;
        reg_write            = 1'b1;
        register_destination = DST_R31;
        memory_to_register   = WB_PC;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PC_RS;
      end
      S_TRAP: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver walks an instruction-level model and queues the
// expected control word for every cycle; a negedge monitor compares them.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst, run, mem_ready;
  logic [5:0] opcode, functi;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, branch, alu_src_a;
  logic [1:0] alu_src_b, alu_operation, register_destination, memory_to_register, pc_source;
  logic       illegal, bus_error, halted;

  typedef struct packed {
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, branch, alu_src_a;
    logic [1:0] src_b, alu_op, reg_dst, mem_to_reg, pc_src;
    logic       illegal, bus_error, halted;
  } ctl_t;

  typedef struct {
    ctl_t  w;
    string tag;
  } exp_t;

  ctl_t act;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [5:0] cur_op, cur_fn;
  bit   exp_ill, exp_bus;

  multicycle_controller #(.OP_W(6), .FN_W(6), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .run                  (run),
    .opcode               (opcode),
    .functi               (functi),
    .mem_ready            (mem_ready),
    .pc_write             (pc_write),
    .ir_write             (ir_write),
    .iord                 (iord),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .reg_write            (reg_write),
    .branch               (branch),
    .alu_src_a            (alu_src_a),
    .alu_src_b            (alu_src_b),
    .alu_operation        (alu_operation),
    .register_destination (register_destination),
    .memory_to_register   (memory_to_register),
    .pc_source            (pc_source),
    .illegal              (illegal),
    .bus_error            (bus_error),
    .halted               (halted)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, branch, alu_src_a,
                alu_src_b, alu_operation, register_destination, memory_to_register, pc_source,
                illegal, bus_error, halted};

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, act, e.w);
    end
  end

  // Expected control word for each step of an instruction, straight from the
  // per-step signal list of the controller's contract.
  function automatic ctl_t word(input string kind, input bit rdy);
    ctl_t w;
    w = '0;
    case (kind)
      "fetch":  begin w.mem_read = 1; w.src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
      "decode": w.src_b = 2'b11;
      "memadr": begin w.alu_src_a = 1; w.src_b = 2'b10; end
      "memrd":  begin w.iord = 1; w.mem_read = 1; end
      "memwb":  begin w.reg_write = 1; w.mem_to_reg = 2'b01; end
      "memwr":  begin w.iord = 1; w.mem_write = 1; end
      "exec":   begin w.alu_src_a = 1; w.alu_op = 2'b10; end
      "aluwb":  begin w.reg_write = 1; w.reg_dst = 2'b01; end
      "addi":   begin w.alu_src_a = 1; w.src_b = 2'b10; end
      "subi":   begin w.alu_src_a = 1; w.src_b = 2'b10; w.alu_op = 2'b01; end
      "iwb":    w.reg_write = 1;
      "beq":    begin w.alu_src_a = 1; w.alu_op = 2'b01; w.branch = 1; w.pc_src = 2'b01; end
      "jump":   begin w.pc_write = 1; w.pc_src = 2'b10; end
      "jal":    begin
        w.pc_write = 1; w.pc_src = 2'b10; w.reg_write = 1; w.reg_dst = 2'b10; w.mem_to_reg = 2'b10;
      end
      "jr":     begin w.pc_write = 1; w.pc_src = 2'b11; end
      "trap":   begin w.halted = 1; w.illegal = exp_ill; w.bus_error = exp_bus; end
      default:  w = '0;
    endcase
    return w;
  endfunction

  task automatic step(input string kind, input bit rdy, input bit run_v, input bit ir_valid);
    exp_t e;
    mem_ready = rdy;
    run       = run_v;
    if (ir_valid) begin
      opcode = cur_op;
      functi = cur_fn;
    end else begin
      opcode = 6'($urandom);
      functi = 6'($urandom);
    end
    e.w   = word(kind, rdy);
    e.tag = kind;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  // A memory step with `waits` not-ready cycles; TIMEOUT of them traps the bus.
  task automatic wait_phase(input string kind, input int waits, input bit ir_valid,
                            output bit trapped);
    int n;
    n = (waits < TIMEOUT) ? waits : TIMEOUT;
    for (int i = 0; i < n; i++) step(kind, 1'b0, rnd(), ir_valid);
    if (waits >= TIMEOUT) begin
      trapped = 1'b1;
      exp_bus = 1'b1;
    end else begin
      trapped = 1'b0;
      step(kind, 1'b1, rnd(), ir_valid);
    end
  endtask

  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, output bit trapped);
    cur_op = op;
    cur_fn = fn;
    wait_phase("fetch", fw, 1'b0, trapped);
    if (trapped) return;
    step("decode", rnd(), rnd(), 1'b1);
    case (op)
      OP_LW: begin
        step("memadr", rnd(), rnd(), 1'b1);
        wait_phase("memrd", mw, 1'b1, trapped);
        if (!trapped) step("memwb", rnd(), rnd(), 1'b1);
      end
      OP_SW: begin
        step("memadr", rnd(), rnd(), 1'b1);
        wait_phase("memwr", mw, 1'b1, trapped);
      end
      OP_RTYPE: begin
        if (fn == FN_JR) begin
          step("jr", rnd(), rnd(), 1'b1);
        end else begin
          step("exec", rnd(), rnd(), 1'b1);
          step("aluwb", rnd(), rnd(), 1'b1);
        end
      end
      OP_ADDI: begin step("addi", rnd(), rnd(), 1'b1); step("iwb", rnd(), rnd(), 1'b1); end
      OP_SUBI: begin step("subi", rnd(), rnd(), 1'b1); step("iwb", rnd(), rnd(), 1'b1); end
      OP_BEQ:  step("beq", rnd(), rnd(), 1'b1);
      OP_J:    step("jump", rnd(), rnd(), 1'b1);
      OP_JAL:  step("jal", rnd(), rnd(), 1'b1);
      default: begin
        exp_ill = 1'b1;
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic idle(input int n, input bit run_v);
    for (int i = 0; i < n; i++) step("idle", rnd(), run_v, 1'b0);
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) step("trap", rnd(), 1'(i), 1'b0);
  endtask

  task automatic do_reset(input string name);
    ctl_t zero;
    zero = '0;
    rst  = 1'b1;
    run  = 1'b0;
    #1;
    check(name, act, zero);
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fn;
    bit         t;
    ctl_t       zero;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_J, OP_JAL};
    zero = '0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; functi = '0;
    #3;
    check("reset_state", act, zero);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b0);
    idle(1, 1'b1);

    exec_instr(OP_LW, 6'd0, 0, 0, t);
    exec_instr(OP_JAL, 6'd0, 0, 0, t);
    exec_instr(OP_RTYPE, FN_JR, 0, 0, t);
    exec_instr(OP_SUBI, 6'd0, 0, 0, t);
    exec_instr(OP_ADDI, 6'd0, 0, 0, t);
    exec_instr(OP_RTYPE, 6'b100000, 0, 0, t);
    exec_instr(OP_SW, 6'd0, 0, 0, t);
    exec_instr(OP_BEQ, 6'd0, 0, 0, t);
    exec_instr(OP_J, 6'd0, 0, 0, t);

    for (int i = 0; i < 60; i++) begin
      fn = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom);
      exec_instr(ops[$urandom_range(0, 7)], fn, $urandom_range(0, TIMEOUT - 1),
                 $urandom_range(0, TIMEOUT - 1), t);
    end

    // Store stalls past the timeout, then a store whose ready lands just in time.
    exec_instr(OP_SW, 6'd0, 0, TIMEOUT, t);
    trap_hold(4);
    do_reset("reset_after_bus_error");
    idle(1, 1'b0);
    idle(1, 1'b1);
    exec_instr(OP_SW, 6'd0, 0, TIMEOUT - 1, t);
    exec_instr(OP_J, 6'd0, 0, 0, t);

    // Abort a load in the middle of its memory wait.
    cur_op = OP_LW;
    cur_fn = 6'd0;
    step("fetch", 1'b1, 1'b0, 1'b0);
    step("decode", 1'b0, 1'b0, 1'b1);
    step("memadr", 1'b0, 1'b0, 1'b1);
    step("memrd", 1'b0, 1'b0, 1'b1);
    step("memrd", 1'b0, 1'b0, 1'b1);
    do_reset("reset_mid_memrd");
    idle(4, 1'b0);
    idle(1, 1'b1);

    exec_instr(6'b101010, 6'd0, 0, 0, t);
    trap_hold(4);
    do_reset("reset_after_illegal");
    idle(1, 1'b0);
    idle(1, 1'b1);

    exec_instr(OP_J, 6'd0, TIMEOUT, 0, t);
    trap_hold(2);
    do_reset("reset_after_fetch_timeout");
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
